stopwatch_counter: RTL and testbench

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

---
 rtl/stopwatch_counter_pkg.sv | 20 ++
 rtl/stopwatch_counter_bcd_digit_counter.sv | 34 +++
 rtl/stopwatch_counter.sv | 113 +++++++++++
 tb/tb_stopwatch_counter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_counter_pkg.sv
// Shared BCD digit definitions for the stopwatch counter and its digit counters.
package stopwatch_counter_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned ONES_MAX = 9;
  localparam int unsigned TENS_MAX = 5;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Four-digit mm:ss time value, most significant digit first.
  typedef struct packed {
    digit_t min_t;
    digit_t min_o;
    digit_t sec_t;
    digit_t sec_o;
  } bcd_time_t;

  localparam bcd_time_t TIME_ZERO = '0;

endpackage

// File: rtl/stopwatch_counter_bcd_digit_counter.sv
// One BCD digit counting 0..MAX, with a carry out in the cycle it rolls over.
module bcd_digit_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int unsigned MAX = ONES_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  digit_t r_digit;
  logic   w_at_max;

  assign w_at_max = (r_digit == digit_t'(MAX));

  // Digit register: clear wins over increment; rolls MAX -> 0 so it stays in range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= '0;
    end else if (clr) begin
      r_digit <= '0;
    end else if (inc) begin
      r_digit <= w_at_max ? '0 : r_digit + digit_t'(1);
    end
  end

  assign digit = r_digit;
  assign carry = inc & w_at_max;

endmodule

// File: rtl/stopwatch_counter.sv
// mm:ss stopwatch: run-gated prescaler, rippled BCD digits, lap freeze and rollover pulse.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int unsigned TICK_DIV = 40_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               clr,
  input  logic               lap,
  output logic [DIGIT_W-1:0] sec_o,
  output logic [DIGIT_W-1:0] sec_t,
  output logic [DIGIT_W-1:0] min_o,
  output logic [DIGIT_W-1:0] min_t,
  output logic               lap_active,
  output logic               wrap
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_presc;
  logic             w_tick;
  logic [3:0]       w_carry;
  bcd_time_t        w_live;
  bcd_time_t        w_disp;
  bcd_time_t        r_snap;
  logic             r_lap_active;
  logic             r_wrap;

  assign w_tick = run & (r_presc == TICK_LAST);

  // Prescaler: advances only while running, holds its fraction on pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (clr) begin
      r_presc <= '0;
    end else if (run) begin
      r_presc <= w_tick ? '0 : r_presc + CNT_W'(1);
    end
  end

  bcd_digit_counter #(.MAX(ONES_MAX)) u_sec_o (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_tick),
    .clr   (clr),
    .digit (w_live.sec_o),
    .carry (w_carry[0])
  );

  bcd_digit_counter #(.MAX(TENS_MAX)) u_sec_t (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_carry[0]),
    .clr   (clr),
    .digit (w_live.sec_t),
    .carry (w_carry[1])
  );

  bcd_digit_counter #(.MAX(ONES_MAX)) u_min_o (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_carry[1]),
    .clr   (clr),
    .digit (w_live.min_o),
    .carry (w_carry[2])
  );

  bcd_digit_counter #(.MAX(TENS_MAX)) u_min_t (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_carry[2]),
    .clr   (clr),
    .digit (w_live.min_t),
    .carry (w_carry[3])
  );

  // Lap freeze toggle; the snapshot captures the pre-tick time on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lap_active <= 1'b0;
      r_snap       <= TIME_ZERO;
    end else if (clr) begin
      r_lap_active <= 1'b0;
    end else if (lap) begin
      if (!r_lap_active) begin
        r_snap <= w_live;
      end
      r_lap_active <= ~r_lap_active;
    end
  end

  // Rollover pulse, aligned with the cycle the time reads 00:00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_carry[3] & ~clr;
    end
  end

  assign w_disp     = r_lap_active ? r_snap : w_live;
  assign sec_o      = w_disp.sec_o;
  assign sec_t      = w_disp.sec_t;
  assign min_o      = w_disp.min_o;
  assign min_t      = w_disp.min_t;
  assign lap_active = r_lap_active;
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter with a seconds-based reference model.
module tb_stopwatch_counter;

  localparam int unsigned TD = 4;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       clr;
  logic       lap;
  logic [3:0] sec_o, sec_t, min_o, min_t;
  logic       lap_active;
  logic       wrap;

  stopwatch_counter #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .clr        (clr),
    .lap        (lap),
    .sec_o      (sec_o),
    .sec_t      (sec_t),
    .min_o      (min_o),
    .min_t      (min_t),
    .lap_active (lap_active),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] disp;
    logic        lap_a;
    logic        wrp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: elapsed seconds, prescaler phase, freeze state.
  int m_time = 0;
  int m_ps   = 0;
  int m_snap = 0;
  bit m_lap  = 0;
  bit m_wrap = 0;

  function automatic logic [15:0] to_bcd(input int secs);
    int mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] dut_disp();
    return {min_t, min_o, sec_t, sec_o};
  endfunction

  task automatic check(input string name, input logic [15:0] act_d, input logic act_l,
                       input logic act_w, input exp_t e);
    checks++;
    if (act_d !== e.disp || act_l !== e.lap_a || act_w !== e.wrp) begin
      errors++;
      $display("FAIL %s @%0t: got disp=%h lap=%b wrap=%b, want disp=%h lap=%b wrap=%b",
               name, $time, act_d, act_l, act_w, e.disp, e.lap_a, e.wrp);
    end
  endtask

  function automatic void model_reset();
    m_time = 0; m_ps = 0; m_snap = 0; m_lap = 0; m_wrap = 0;
  endfunction

  function automatic void model_step(input bit r, input bit c, input bit l);
    bit tick;
    if (c) begin
      m_time = 0; m_ps = 0; m_lap = 0; m_wrap = 0;
      return;
    end
    tick = r && (m_ps == TD - 1);
    if (l) begin
      if (!m_lap) m_snap = m_time;
      m_lap = !m_lap;
    end
    if (r) m_ps = tick ? 0 : m_ps + 1;
    m_wrap = tick && (m_time == 3599);
    if (tick) m_time = (m_time + 1) % 3600;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.disp  = to_bcd(m_lap ? m_snap : m_time);
    e.lap_a = m_lap;
    e.wrp   = m_wrap;
    return e;
  endfunction

  // One clock of stimulus; the expected post-edge response goes to the scoreboard.
  task automatic cycle(input bit r, input bit c, input bit l, input bit in_rst = 1'b0);
    @(negedge clk);
    run = r; clr = c; lap = l;
    if (in_rst) begin
      rst_n = 1'b0;
      model_reset();
    end else begin
      rst_n = 1'b1;
      model_step(r, c, l);
    end
    sb_q.push_back(model_out());
  endtask

  task automatic run_cycles(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(r, 1'b0, 1'b0);
  endtask

  // Monitor: the display is presented every cycle, so compare one entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("display", dut_disp(), lap_active, wrap, e);
      end
    end
  end

  initial begin
    exp_t zero_e;
    zero_e.disp = '0; zero_e.lap_a = 1'b0; zero_e.wrp = 1'b0;
    rst_n = 1'b0; run = 1'b0; clr = 1'b0; lap = 1'b0;
    #1;
    check("reset_state", dut_disp(), lap_active, wrap, zero_e);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1);

    // Forty running cycles give ten seconds.
    run_cycles(40, 1'b1);

    // Pause keeps the prescaler fraction.
    cycle(1'b0, 1'b1, 1'b0);
    run_cycles(6, 1'b1);
    run_cycles(20, 1'b0);
    run_cycles(2, 1'b1);

    // Lap freeze at 00:07 while counting continues, then release.
    cycle(1'b0, 1'b1, 1'b0);
    run_cycles(28, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    run_cycles(12, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    run_cycles(4, 1'b1);

    // Frozen at 12:34, then clr lands together with a tick and a lap pulse.
    cycle(1'b0, 1'b1, 1'b0);
    run_cycles(754 * TD, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    run_cycles(2, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    run_cycles(3, 1'b0);

    // Full hour to reach the 59:59 -> 00:00 rollover.
    cycle(1'b0, 1'b1, 1'b0);
    run_cycles(3600 * TD + 2 * TD, 1'b1);

    // Asynchronous reset in the middle of a second.
    cycle(1'b0, 1'b1, 1'b0);
    run_cycles(4 + 2, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", dut_disp(), lap_active, wrap, zero_e);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    run_cycles(6, 1'b1);

    // Random mix of run, clr and lap.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 19) == 0));
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
